// File: rtl/ws_block.sv
// Write-back engine: streams one 8x8 block of reconstructed S values out of DPRAM,
// clips each to 8 bits, packs pixel pairs and writes them to the Y/U/V planes in SRAM.
module ws_block #(
  parameter logic [17:0] Y_BASE = 18'd0,
  parameter logic [17:0] U_BASE = 18'd38400,
  parameter logic [17:0] V_BASE = 18'd57600
) (
  input  logic        CLOCK_50_I,
  input  logic        Reset,
  input  logic        WS_start,
  output logic        WS_done,
  output logic        WS_frame_done,
  output logic [6:0]  WS_read_address,
  input  logic [31:0] WS_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  typedef enum logic [2:0] {
    S_WS_IDLE,
    S_WS_LI,
    S_WS_CC,
    S_WS_LO_1,
    S_WS_LO_2
  } ws_state_t;

  localparam logic [1:0] PL_Y = 2'd0;
  localparam logic [1:0] PL_U = 2'd1;
  localparam logic [1:0] PL_V = 2'd2;

  ws_state_t   state;
  logic [1:0]  plane;
  logic [5:0]  cb;
  logic [4:0]  rb;
  logic [5:0]  k;
  logic [7:0]  even_pix;

  logic [7:0]  clip;
  logic [17:0] base, rb_off, r_off, wr_addr;
  logic [2:0]  r;
  logic [1:0]  c;
  logic [5:0]  cb_end;
  logic        last_block;

  always_comb begin
    clip = WS_read_data[7:0];
    if (WS_read_data[31])          clip = 8'h00;
    else if (|WS_read_data[30:8])  clip = 8'hFF;
  end

  // k is the odd element of the pair being written; k[5:1] equals that of k-1.
  assign r = k[5:3];
  assign c = k[2:1];

  // Row strides: Y S=160 (block row 1280), U/V S=80 (block row 640), built from shifts.
  always_comb begin
    base   = Y_BASE;
    rb_off = ({13'd0, rb} << 10) + ({13'd0, rb} << 8);
    r_off  = ({15'd0, r} << 7) + ({15'd0, r} << 5);
    cb_end = 6'd39;
    if (plane != PL_Y) begin
      base   = (plane == PL_U) ? U_BASE : V_BASE;
      rb_off = ({13'd0, rb} << 9) + ({13'd0, rb} << 7);
      r_off  = ({15'd0, r} << 6) + ({15'd0, r} << 4);
      cb_end = 6'd19;
    end
  end

  assign wr_addr    = base + rb_off + r_off + {10'd0, cb, 2'b00} + {16'd0, c};
  assign last_block = (plane == PL_V) && (cb == 6'd19) && (rb == 5'd29);

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      state           <= S_WS_IDLE;
      plane           <= PL_Y;
      cb              <= 6'd0;
      rb              <= 5'd0;
      k               <= 6'd0;
      even_pix        <= 8'd0;
      WS_done         <= 1'b0;
      WS_frame_done   <= 1'b0;
      WS_read_address <= 7'd0;
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
      SRAM_we_n       <= 1'b1;
    end else begin
      WS_done       <= 1'b0;
      WS_frame_done <= 1'b0;
      SRAM_we_n     <= 1'b1;
      case (state)
        S_WS_IDLE: begin
          if (WS_start) begin
            WS_read_address <= 7'd0;
            k               <= 6'd0;
            state           <= S_WS_LI;
          end
        end
        S_WS_LI: begin
          WS_read_address <= 7'd1;
          state           <= S_WS_CC;
        end
        S_WS_CC: begin
          // Read address runs two elements ahead of the captured data.
          if (WS_read_address != 7'd63)
            WS_read_address <= WS_read_address + 7'd1;
          if (!k[0]) begin
            even_pix <= clip;
          end else begin
            SRAM_we_n       <= 1'b0;
            SRAM_address    <= wr_addr;
            SRAM_write_data <= {even_pix, clip};
          end
          k <= k + 6'd1;
          if (k == 6'd62) state <= S_WS_LO_1;
        end
        S_WS_LO_1: begin
          SRAM_we_n       <= 1'b0;
          SRAM_address    <= wr_addr;
          SRAM_write_data <= {even_pix, clip};
          state           <= S_WS_LO_2;
        end
        S_WS_LO_2: begin
          WS_done <= 1'b1;
          k       <= 6'd0;
          state   <= S_WS_IDLE;
          if (cb != cb_end) begin
            cb <= cb + 6'd1;
          end else begin
            cb <= 6'd0;
            if (rb != 5'd29) begin
              rb <= rb + 5'd1;
            end else begin
              rb <= 5'd0;
              case (plane)
                PL_Y:    plane <= PL_U;
                PL_U:    plane <= PL_V;
                default: plane <= PL_Y;
              endcase
            end
          end
          if (last_block) WS_frame_done <= 1'b1;
        end
        default: state <= S_WS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws_block.sv
// Directed bench for ws_block: DPRAM read model, SRAM write log, per-feature tasks.
module tb_ws_block;

  logic        CLOCK_50_I = 1'b0;
  logic        Reset = 1'b1;
  logic        WS_start = 1'b0;
  logic        WS_done, WS_frame_done, SRAM_we_n;
  logic [6:0]  WS_read_address;
  logic [31:0] WS_read_data = 32'd0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;

  ws_block dut (
    .CLOCK_50_I      (CLOCK_50_I),
    .Reset           (Reset),
    .WS_start        (WS_start),
    .WS_done         (WS_done),
    .WS_frame_done   (WS_frame_done),
    .WS_read_address (WS_read_address),
    .WS_read_data    (WS_read_data),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n)
  );

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  int cyc = 0;
  always @(posedge CLOCK_50_I) cyc <= cyc + 1;

  logic [31:0] dpram [64];
  always @(posedge CLOCK_50_I) WS_read_data <= dpram[WS_read_address[5:0]];

  int          n_chk = 0;
  int          n_fail = 0;
  logic [17:0] wa[$];
  logic [15:0] wd[$];
  int          wc[$];
  int          s_cyc, done_cyc;
  logic        fd_seen;

  function automatic int exp_addr(int base, int s, int rb, int cb, int i);
    return base + rb * 8 * s + (i / 4) * s + cb * 4 + (i % 4);
  endfunction

  // Pulse start at cycle s_cyc and log every write until WS_done (done_cyc=-1 on timeout).
  task automatic run_block;
    wa.delete(); wd.delete(); wc.delete();
    done_cyc = -1;
    fd_seen  = 1'b0;
    @(negedge CLOCK_50_I);
    WS_start = 1'b1;
    s_cyc    = cyc;
    @(negedge CLOCK_50_I);
    WS_start = 1'b0;
    for (int n = 0; n < 200 && done_cyc < 0; n++) begin
      if (!SRAM_we_n) begin
        wa.push_back(SRAM_address);
        wd.push_back(SRAM_write_data);
        wc.push_back(cyc);
      end
      if (WS_done) begin
        done_cyc = cyc;
        fd_seen  = WS_frame_done;
      end
      if (done_cyc < 0) @(negedge CLOCK_50_I);
    end
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    repeat (2) @(negedge CLOCK_50_I);
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    WS_start = 1'b0;
    Reset    = 1'b1;
    repeat (2) @(negedge CLOCK_50_I);
    n_chk++; if ({WS_done, WS_frame_done, SRAM_we_n} !== 3'b001) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 001", {WS_done, WS_frame_done, SRAM_we_n});
    end
    n_chk++; if (SRAM_address !== 18'd0 || SRAM_write_data !== 16'd0) begin
      n_fail++; $display("FAIL reset_sram: got %h/%h expected 0/0", SRAM_address, SRAM_write_data);
    end
    n_chk++; if (WS_read_address !== 7'd0) begin
      n_fail++; $display("FAIL reset_rdaddr: got %0d expected 0", WS_read_address);
    end
    Reset = 1'b0;
  endtask

  task automatic test_ramp;
    int bad_a, bad_d, bad_c;
    for (int i = 0; i < 64; i++) dpram[i] = 32'(i);
    run_block();
    n_chk++; if (wa.size() != 32) begin
      n_fail++; $display("FAIL ramp_count: got %0d writes expected 32", wa.size());
    end
    if (wa.size() == 32) begin
      n_chk++; if (wa[0] !== 18'd0 || wd[0] !== 16'h0001) begin
        n_fail++; $display("FAIL ramp_w0: got %0d/%h expected 0/0001", wa[0], wd[0]);
      end
      n_chk++; if (wa[1] !== 18'd1 || wd[1] !== 16'h0203) begin
        n_fail++; $display("FAIL ramp_w1: got %0d/%h expected 1/0203", wa[1], wd[1]);
      end
      n_chk++; if (wa[4] !== 18'd160 || wd[4] !== 16'h0809) begin
        n_fail++; $display("FAIL ramp_w4: got %0d/%h expected 160/0809", wa[4], wd[4]);
      end
      n_chk++; if (wa[31] !== 18'd1123 || wd[31] !== 16'h3E3F) begin
        n_fail++; $display("FAIL ramp_w31: got %0d/%h expected 1123/3e3f", wa[31], wd[31]);
      end
      bad_a = 0; bad_d = 0; bad_c = 0;
      for (int i = 0; i < 32; i++) begin
        if (wa[i] !== 18'(exp_addr(0, 160, 0, 0, i))) bad_a++;
        if (wd[i] !== {8'(2 * i), 8'(2 * i + 1)}) bad_d++;
        if (wc[i] != s_cyc + 4 + 2 * i) bad_c++;
      end
      n_chk++; if (bad_a != 0) begin
        n_fail++; $display("FAIL ramp_addrs: got %0d wrong addresses expected 0", bad_a);
      end
      n_chk++; if (bad_d != 0) begin
        n_fail++; $display("FAIL ramp_data: got %0d wrong words expected 0", bad_d);
      end
      n_chk++; if (bad_c != 0) begin
        n_fail++; $display("FAIL ramp_timing: got %0d writes off cycle 4+2i expected 0", bad_c);
      end
    end
    n_chk++; if (done_cyc != s_cyc + 67) begin
      n_fail++; $display("FAIL ramp_done: got cycle %0d expected %0d", done_cyc - s_cyc, 67);
    end
    n_chk++; if (fd_seen !== 1'b0) begin
      n_fail++; $display("FAIL ramp_framedone: got %b expected 0", fd_seen);
    end
  endtask

  task automatic test_clip;
    do_reset();
    dpram[0] = 32'hFFFF_FFFB;
    dpram[1] = 32'd300;
    dpram[2] = 32'd255;
    dpram[3] = 32'h8000_0000;
    run_block();
    n_chk++; if (wa.size() != 32 || wa[0] !== 18'd0 || wd[0] !== 16'h00FF) begin
      n_fail++; $display("FAIL clip_w0: got %0d/%h expected 0/00ff", wa[0], wd[0]);
    end
    n_chk++; if (wa.size() != 32 || wa[1] !== 18'd1 || wd[1] !== 16'hFF00) begin
      n_fail++; $display("FAIL clip_w1: got %0d/%h expected 1/ff00", wa[1], wd[1]);
    end
  endtask

  task automatic test_sequencing;
    int to;
    run_block();
    n_chk++; if (wa.size() == 0 || wa[0] !== 18'd4) begin
      n_fail++; $display("FAIL seq_block1: got %0d expected 4", wa.size() ? wa[0] : 18'h3FFFF);
    end
    to = 0;
    for (int b = 2; b < 40; b++) begin
      run_block();
      if (done_cyc < 0) to++;
    end
    n_chk++; if (to != 0) begin
      n_fail++; $display("FAIL seq_timeouts: got %0d expected 0", to);
    end
    run_block();
    n_chk++; if (wa.size() == 0 || wa[0] !== 18'd1280) begin
      n_fail++; $display("FAIL seq_block40: got %0d expected 1280", wa.size() ? wa[0] : 18'h3FFFF);
    end
    // Jump to Y block (CB=38, RB=29) rather than stepping 1198 blocks.
    @(negedge CLOCK_50_I);
    force dut.plane = 2'd0;
    force dut.rb = 5'd29;
    force dut.cb = 6'd38;
    @(posedge CLOCK_50_I); #1;
    release dut.plane;
    release dut.rb;
    release dut.cb;
    run_block();
    run_block();
    n_chk++; if (wa.size() != 32 || wa[31] !== 18'd38399) begin
      n_fail++; $display("FAIL seq_block1199: got %0d expected 38399", wa.size() ? wa[wa.size() - 1] : 18'h3FFFF);
    end
    run_block();
    n_chk++; if (wa.size() != 32 || wa[0] !== 18'd38400 || wa[4] !== 18'd38480) begin
      n_fail++; $display("FAIL seq_block1200: got %0d/%0d expected 38400/38480",
                         wa.size() ? wa[0] : 18'h3FFFF, wa.size() > 4 ? wa[4] : 18'h3FFFF);
    end
  endtask

  task automatic test_last_v;
    @(negedge CLOCK_50_I);
    force dut.plane = 2'd2;
    force dut.rb = 5'd29;
    force dut.cb = 6'd18;
    @(posedge CLOCK_50_I); #1;
    release dut.plane;
    release dut.rb;
    release dut.cb;
    run_block();
    n_chk++; if (fd_seen !== 1'b0) begin
      n_fail++; $display("FAIL lastv_early_fd: got %b expected 0", fd_seen);
    end
    run_block();
    n_chk++; if (wa.size() != 32 || wa[31] !== 18'd76799) begin
      n_fail++; $display("FAIL lastv_addr: got %0d expected 76799", wa.size() ? wa[wa.size() - 1] : 18'h3FFFF);
    end
    n_chk++; if (fd_seen !== 1'b1 || done_cyc < 0) begin
      n_fail++; $display("FAIL lastv_framedone: got %b (done %0d) expected 1", fd_seen, done_cyc);
    end
    run_block();
    n_chk++; if (wa.size() == 0 || wa[0] !== 18'd0) begin
      n_fail++; $display("FAIL lastv_wrap: got %0d expected 0", wa.size() ? wa[0] : 18'h3FFFF);
    end
  endtask

  task automatic test_reset_mid;
    int nw, nd;
    @(negedge CLOCK_50_I);
    WS_start = 1'b1;
    s_cyc    = cyc;
    @(negedge CLOCK_50_I);
    WS_start = 1'b0;
    while (cyc < s_cyc + 30) @(negedge CLOCK_50_I);
    Reset = 1'b1;
    @(negedge CLOCK_50_I);
    n_chk++; if (SRAM_we_n !== 1'b1) begin
      n_fail++; $display("FAIL midrst_we: got %b expected 1", SRAM_we_n);
    end
    Reset = 1'b0;
    nw = 0; nd = 0;
    repeat (100) begin
      @(negedge CLOCK_50_I);
      if (!SRAM_we_n) nw++;
      if (WS_done) nd++;
    end
    n_chk++; if (nw != 0 || nd != 0) begin
      n_fail++; $display("FAIL midrst_quiet: got %0d writes %0d done expected 0 0", nw, nd);
    end
    run_block();
    n_chk++; if (wa.size() != 32 || wa[0] !== 18'd0) begin
      n_fail++; $display("FAIL midrst_restart: got %0d expected 0", wa.size() ? wa[0] : 18'h3FFFF);
    end
  endtask

  task automatic test_back_to_back;
    int d[2];
    int nd, nw, first_ok;
    nd = 0; nw = 0; first_ok = 1;
    @(negedge CLOCK_50_I);
    WS_start = 1'b1;
    s_cyc    = cyc;
    for (int n = 0; n < 300 && nd < 2; n++) begin
      @(negedge CLOCK_50_I);
      if (!SRAM_we_n) begin
        nw++;
        if (nd == 0 && ((cyc - s_cyc) % 2 != 0 || cyc - s_cyc < 4 || cyc - s_cyc > 66)) first_ok = 0;
      end
      if (WS_done) begin
        d[nd] = cyc;
        nd++;
        if (nd == 2) WS_start = 1'b0;
      end
    end
    WS_start = 1'b0;
    n_chk++; if (nd != 2) begin
      n_fail++; $display("FAIL b2b_dones: got %0d expected 2", nd);
    end
    if (nd == 2) begin
      n_chk++; if (d[0] != s_cyc + 67) begin
        n_fail++; $display("FAIL b2b_first_done: got cycle %0d expected 67", d[0] - s_cyc);
      end
      n_chk++; if (d[1] - d[0] != 67) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d expected 67", d[1] - d[0]);
      end
    end
    n_chk++; if (nw != 64 || first_ok != 1) begin
      n_fail++; $display("FAIL b2b_writes: got %0d writes (first block ok=%0d) expected 64 (1)", nw, first_ok);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) dpram[i] = 32'd0;
    test_reset();
    test_ramp();
    test_clip();
    test_sequencing();
    test_last_v();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ws_block.md
Name: ws_block

Overview:
- Write-back engine for milestone 2; the inverse of the S'-fetch path.
- Reads one 8x8 block of reconstructed S values (32-bit signed) from the top half of DPRAM (addresses 0-63).
- Clips each value to 8 bits and packs two pixels per 16-bit word.
- Writes the block's 32 words to the Y/U/V region of SRAM (Y base 0, U 38400, V 57600). Tracks block position across the whole frame.

Parameters:
- Y_BASE, 0, SRAM word address of the Y plane
- U_BASE, 38400, SRAM word address of the U plane
- V_BASE, 57600, SRAM word address of the V plane

Ports:
- CLOCK_50_I  in  1  system clock, 50 MHz
- Reset  in  1  synchronous reset, active-high
- WS_start  in  1  one-cycle start pulse; sampled only in S_WS_IDLE
- WS_done  out  1  one-cycle pulse when the block's last SRAM write has been issued
- WS_frame_done  out  1  one-cycle pulse, coincident with WS_done, for the last V block
- WS_read_address  out  7  DPRAM read address, range 0-63
- WS_read_data  in  32  DPRAM read data, signed; valid 1 cycle after the address
- SRAM_address  out  18  SRAM word address
- SRAM_write_data  out  16  {even pixel[15:8], odd pixel[7:0]}
- SRAM_we_n  out  1  SRAM write enable, active-low

Behaviour:
- Interface: one clock, CLOCK_50_I; reset is synchronous and active-high (Reset).
- Reset values: WS_done=0, WS_frame_done=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, WS_read_address=0, state=S_WS_IDLE, plane=Y, CB=0, RB=0, element counter k=0.
- Reset mid-block aborts immediately with the same values; no partial write is completed.
- FSM states: S_WS_IDLE -> S_WS_LI -> S_WS_CC -> S_WS_LO_1 -> S_WS_LO_2 -> S_WS_IDLE.
- Start: WS_start in S_WS_IDLE at cycle 0 drives WS_read_address=0 from cycle 1; address k is presented at cycle k+1, k=0..63.
- WS_start outside S_WS_IDLE is ignored.
- Data arrival: data for element k is valid at cycle k+2.
- Clipping: value <0 -> 0x00; value >255 -> 0xFF; otherwise value[7:0].
- Even k: the clipped value is registered.
- Odd k: at the next cycle, SRAM_we_n=0, SRAM_address=addr(k-1), SRAM_write_data={clip(k-1), clip(k)}.
- SRAM_we_n=1 on every cycle that is not a write cycle. Writes occur on cycles 4,6,...,66: exactly 32 writes.
- Address: for element k, r=k[5:3] and c=k[2:1]. addr = base + RB*8*S + r*S + CB*4 + c.
  - S=160 for Y and 80 for U/V.
  - Use shift-add arithmetic only; no multiplier.
- WS_done pulses at cycle 67, and the FSM re-enters S_WS_IDLE.
- Block advance happens at the WS_done cycle:
  - CB+1, until CB_END (39 for Y, 19 for U/V).
  - Then CB=0 and RB+1, until 29.
  - Then RB=0 and plane Y->U->V.
  - After the last V block, the plane wraps to Y with CB=RB=0 and WS_frame_done pulses with WS_done.
- Back-to-back: WS_start asserted on the WS_done+1 cycle starts the next block with no lost cycles.

Test Plan:
1. Reset, then DPRAM[k]=k and pulse WS_start -> 32 writes:
   - addr 0 = 0x0001, addr 1 = 0x0203, addr 160 = 0x0809, addr 1123 = 0x3E3F
   - WS_done at cycle 67; SRAM_we_n high between writes.
2. Clipping: DPRAM[0]=-5, DPRAM[1]=300, DPRAM[2]=255, DPRAM[3]=0x80000000 -> addr 0 = 0x00FF, addr 1 = 0xFF00.
3. Block sequencing:
   - Second block's first write goes to addr 4.
   - Block 40 (RB=1) writes first to 1280.
   - Block 1199 writes last to 38399.
   - Block 1200 writes first to 38400, row 1 to 38480.
4. Last V block (plane V, CB=19, RB=29) -> last write to addr 76799; WS_frame_done=1 with WS_done; next block writes to addr 0.
5. Reset asserted at cycle 30 of a block -> SRAM_we_n=1 next cycle and no further writes; the following WS_start writes to addr 0.
6. WS_start held high throughout a block -> no restart mid-block; back-to-back blocks complete in 67-cycle spacing.
